// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the main-memory fill arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    FILL_ISSUE = 2'd1,
    FILL_DRAIN = 2'd2,
    STORE      = 2'd3
  } state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_t;

  localparam int BLOCK_OFS_BITS = 4;
  localparam int WORD_IDX_BITS  = 3;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: on a tie, the requester not granted last time wins.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  req_id_t last_grant;

  always_comb begin
    // NOTE: default assigned first so every path drives gnt and no latch is inferred.
    gnt = 2'b00;
    if (req == 2'b11) begin
      gnt = (last_grant == REQ_I) ? 2'b10 : 2'b01;
    end else begin
      gnt = req;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking so every flop samples pre-edge values regardless of block order.
    if (!rst_n) begin
      last_grant <= REQ_I;
    end else if (en && (gnt != 2'b00)) begin
      last_grant <= gnt[1] ? REQ_D : REQ_I;
    end
  end

endmodule

// File: rtl/mem_fill_arbiter.sv
// Shares the main-memory port between I-cache fills and D-cache fills/stores,
// issuing 8-word block fills as pipelined reads and routing returns back.
module mem_fill_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AWIDTH          = 16,
  parameter int DWIDTH          = 16,
  parameter int WORDS_PER_BLOCK = 8,
  parameter int MEM_LAT         = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ic_req,
  input  logic [AWIDTH-1:0] ic_addr,
  output logic              ic_grant,
  output logic              ic_fill_valid,
  output logic              ic_done,
  input  logic              dc_req,
  input  logic              dc_wr,
  input  logic [AWIDTH-1:0] dc_addr,
  input  logic [DWIDTH-1:0] dc_wdata,
  output logic              dc_grant,
  output logic              dc_fill_valid,
  output logic              dc_done,
  output logic [DWIDTH-1:0] fill_data,
  output logic [2:0]        fill_idx,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  input  logic [DWIDTH-1:0] mem_rdata,
  input  logic              mem_rvalid
);

  localparam int BASE_BITS = AWIDTH - BLOCK_OFS_BITS;
  localparam logic [WORD_IDX_BITS-1:0] LAST_IDX = WORD_IDX_BITS'(WORDS_PER_BLOCK - 1);

  state_t                   state;
  req_id_t                  owner;
  logic [BASE_BITS-1:0]     base;
  logic [WORD_IDX_BITS-1:0] issue_idx;
  logic [WORD_IDX_BITS-1:0] ret_cnt;
  logic [1:0]               arb_gnt;
  logic                     fill_active;
  logic                     ret_hit;
  logic                     ret_last;
  logic                     unused_bits;

  assign unused_bits = ^{ic_addr[BLOCK_OFS_BITS-1:0], dc_addr[0]};

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state == IDLE),
    .req   ({dc_req, ic_req}),
    .gnt   (arb_gnt)
  );

  // Returns are only meaningful while a fill owns the port; strays elsewhere are dropped.
  assign fill_active = (state == FILL_ISSUE) || (state == FILL_DRAIN);
  assign ret_hit     = fill_active && mem_rvalid;
  assign ret_last    = ret_hit && (ret_cnt == LAST_IDX);

  assign ic_fill_valid = ret_hit && (owner == REQ_I);
  assign dc_fill_valid = ret_hit && (owner == REQ_D);
  assign ic_done       = ret_last && (owner == REQ_I);
  assign dc_done       = (ret_last && (owner == REQ_D)) || (state == STORE);
  assign fill_data     = ret_hit ? mem_rdata : '0;
  assign fill_idx      = ret_cnt;
  assign mem_wdata     = (state == STORE) ? dc_wdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= REQ_I;
      base      <= '0;
      issue_idx <= '0;
      ret_cnt   <= '0;
      ic_grant  <= 1'b0;
      dc_grant  <= 1'b0;
      mem_en    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_gnt[REQ_D]) begin
            owner    <= REQ_D;
            dc_grant <= 1'b1;
            mem_en   <= 1'b1;
            if (dc_wr) begin
              state    <= STORE;
              mem_wr   <= 1'b1;
              mem_addr <= {dc_addr[AWIDTH-1:1], 1'b0};
            end else begin
              state    <= FILL_ISSUE;
              base     <= dc_addr[AWIDTH-1:BLOCK_OFS_BITS];
              mem_addr <= {dc_addr[AWIDTH-1:BLOCK_OFS_BITS], {WORD_IDX_BITS{1'b0}}, 1'b0};
            end
          end else if (arb_gnt[REQ_I]) begin
            owner    <= REQ_I;
            ic_grant <= 1'b1;
            mem_en   <= 1'b1;
            state    <= FILL_ISSUE;
            base     <= ic_addr[AWIDTH-1:BLOCK_OFS_BITS];
            mem_addr <= {ic_addr[AWIDTH-1:BLOCK_OFS_BITS], {WORD_IDX_BITS{1'b0}}, 1'b0};
          end
        end

        FILL_ISSUE, FILL_DRAIN: begin
          if (ret_hit) begin
            ret_cnt <= ret_cnt + 1'b1;
          end
          if (ret_last) begin
            state     <= IDLE;
            ic_grant  <= 1'b0;
            dc_grant  <= 1'b0;
            mem_en    <= 1'b0;
            mem_addr  <= '0;
            issue_idx <= '0;
            ret_cnt   <= '0;
          end else if (state == FILL_ISSUE) begin
            if (issue_idx == LAST_IDX) begin
              state    <= FILL_DRAIN;
              mem_en   <= 1'b0;
              mem_addr <= '0;
            end else begin
              issue_idx <= issue_idx + 1'b1;
              mem_addr  <= {base, issue_idx + 1'b1, 1'b0};
            end
          end
        end

        STORE: begin
          state    <= IDLE;
          dc_grant <= 1'b0;
          mem_en   <= 1'b0;
          mem_wr   <= 1'b0;
          mem_addr <= '0;
        end

        default: state <= IDLE;
      endcase
    end
  end

  // The first return of a fill cannot beat the memory latency of word 0.
  a_no_early_return: assert property (@(posedge clk) disable iff (!rst_n)
    !((state == FILL_ISSUE) && (int'(issue_idx) < MEM_LAT) && mem_rvalid));

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Randomized bench for mem_fill_arbiter against a transaction-timeline model
// plus directed scenarios for ties, stores, stray returns, drops and reset.
module tb_mem_fill_arbiter;

  localparam int AWIDTH  = 16;
  localparam int DWIDTH  = 16;
  localparam int MEM_LAT = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ic_req, dc_req, dc_wr;
  logic [AWIDTH-1:0] ic_addr, dc_addr;
  logic [DWIDTH-1:0] dc_wdata;
  logic              ic_grant, ic_fill_valid, ic_done;
  logic              dc_grant, dc_fill_valid, dc_done;
  logic [DWIDTH-1:0] fill_data;
  logic [2:0]        fill_idx;
  logic              mem_en, mem_wr;
  logic [AWIDTH-1:0] mem_addr;
  logic [DWIDTH-1:0] mem_wdata, mem_rdata;
  logic              mem_rvalid;
  logic              mem_rvalid_q = 1'b0;
  logic [DWIDTH-1:0] mem_rdata_q  = '0;
  logic              stray = 1'b0;

  always #5 clk = ~clk;

  mem_fill_arbiter #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH), .WORDS_PER_BLOCK(8), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_grant(ic_grant),
    .ic_fill_valid(ic_fill_valid), .ic_done(ic_done),
    .dc_req(dc_req), .dc_wr(dc_wr), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_grant(dc_grant), .dc_fill_valid(dc_fill_valid), .dc_done(dc_done),
    .fill_data(fill_data), .fill_idx(fill_idx),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
  );

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  // Main-memory model: fixed-latency in-order reads; a stray pulse can be injected.
  typedef struct { int due; logic [15:0] addr; } rd_t;
  rd_t pend[$];
  int  mcyc = 0;

  assign mem_rvalid = mem_rvalid_q | stray;
  assign mem_rdata  = stray ? 16'hBAD0 : mem_rdata_q;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend.delete();
      mcyc = 0;
      mem_rvalid_q <= 1'b0;
      mem_rdata_q  <= '0;
    end else begin
      if (mem_en && !mem_wr) pend.push_back('{due: mcyc + MEM_LAT, addr: mem_addr});
      mcyc = mcyc + 1;
      if (pend.size() > 0 && pend[0].due == mcyc) begin
        mem_rvalid_q <= 1'b1;
        mem_rdata_q  <= mem_word(pend[0].addr);
        void'(pend.pop_front());
      end else begin
        mem_rvalid_q <= 1'b0;
        mem_rdata_q  <= '0;
      end
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: one transaction at a time, described by its kind and the
  // number of cycles elapsed since its grant.
  typedef enum {T_NONE, T_FILL, T_STORE} txn_kind_e;
  txn_kind_e   t_kind = T_NONE;
  int          t_k;
  bit          t_dc;
  logic [15:0] t_base, t_st_addr, t_st_data;
  bit          last_d = 1'b0;
  bit          started_i, started_d, ended_i, ended_d;

  bit          rand_mode = 1'b0;
  bit          ic_busy, dc_busy, ic_gnt_seen, dc_gnt_seen;
  int          cyc = 0;
  logic [1:0]  obs_grant;
  logic [33:0] obs_mem;
  bit          prev_ig;
  int          ig_rise, idone_cyc, idone_cnt;

  function automatic logic [63:0] out_vec();
    return {5'b0, ic_grant, ic_fill_valid, ic_done, dc_grant, dc_fill_valid, dc_done,
            fill_data, fill_idx, mem_en, mem_wr, mem_addr, mem_wdata};
  endfunction

  task automatic check_cycle();
    logic        e_ig, e_dg, e_en, e_wr, e_ifv, e_dfv, e_idn, e_ddn;
    logic [15:0] e_addr, e_wdata, e_data;
    logic [2:0]  e_idx;
    int          idx;
    {e_ig, e_dg, e_en, e_wr, e_ifv, e_dfv, e_idn, e_ddn} = '0;
    e_addr = '0; e_wdata = '0; e_data = '0; e_idx = '0;
    if (t_kind == T_FILL) begin
      if (t_dc) e_dg = 1'b1; else e_ig = 1'b1;
      if (t_k <= 7) begin
        e_en   = 1'b1;
        e_addr = t_base + 16'(2 * t_k);
      end
      if (t_k >= MEM_LAT) begin
        idx    = t_k - MEM_LAT;
        e_idx  = 3'(idx);
        e_data = mem_word(t_base + 16'(2 * idx));
        if (t_dc) e_dfv = 1'b1; else e_ifv = 1'b1;
        if (idx == 7) begin
          if (t_dc) e_ddn = 1'b1; else e_idn = 1'b1;
        end
      end
    end else if (t_kind == T_STORE) begin
      {e_dg, e_en, e_wr, e_ddn} = 4'b1111;
      e_addr  = t_st_addr;
      e_wdata = t_st_data;
    end
    check("grant", 64'({ic_grant, dc_grant}), 64'({e_ig, e_dg}));
    check("mem_port", 64'({mem_en, mem_wr, mem_addr, mem_wdata}), 64'({e_en, e_wr, e_addr, e_wdata}));
    check("fill_valid", 64'({ic_fill_valid, dc_fill_valid}), 64'({e_ifv, e_dfv}));
    check("done", 64'({ic_done, dc_done}), 64'({e_idn, e_ddn}));
    if (e_ifv || e_dfv) check("fill_word", 64'({fill_idx, fill_data}), 64'({e_idx, e_data}));
  endtask

  task automatic model_step();
    bit pick_d;
    {started_i, started_d, ended_i, ended_d} = '0;
    if (t_kind == T_NONE) begin
      if (ic_req || dc_req) begin
        pick_d = (ic_req && dc_req) ? !last_d : dc_req;
        last_d = pick_d;
        t_dc   = pick_d;
        t_k    = 0;
        if (pick_d) begin
          started_d = 1'b1;
          t_kind    = dc_wr ? T_STORE : T_FILL;
          t_base    = {dc_addr[15:4], 4'h0};
          t_st_addr = {dc_addr[15:1], 1'b0};
          t_st_data = dc_wdata;
        end else begin
          started_i = 1'b1;
          t_kind    = T_FILL;
          t_base    = {ic_addr[15:4], 4'h0};
        end
      end
    end else if (t_kind == T_STORE || t_k == 7 + MEM_LAT) begin
      if (t_dc) ended_d = 1'b1; else ended_i = 1'b1;
      t_kind = T_NONE;
    end else begin
      t_k++;
    end
  endtask

  task automatic drive();
    stray = 1'b0;
    if (ended_i) begin ic_req = 1'b0; ic_busy = 1'b0; ic_gnt_seen = 1'b0; end
    if (ended_d) begin dc_req = 1'b0; dc_busy = 1'b0; dc_gnt_seen = 1'b0; end
    if (started_i) ic_gnt_seen = 1'b1;
    if (started_d) dc_gnt_seen = 1'b1;
    if (rand_mode) begin
      if (!ic_busy) begin
        ic_addr = 16'($urandom);
        if ($urandom_range(0, 2) == 0) begin ic_req = 1'b1; ic_busy = 1'b1; end
      end else if (ic_gnt_seen && $urandom_range(0, 7) == 0) begin
        ic_req = 1'b0;
      end
      if (!dc_busy) begin
        dc_addr  = 16'($urandom);
        dc_wdata = 16'($urandom);
        dc_wr    = ($urandom_range(0, 2) == 0);
        if ($urandom_range(0, 2) == 0) begin dc_req = 1'b1; dc_busy = 1'b1; end
      end else if (dc_gnt_seen && $urandom_range(0, 7) == 0) begin
        dc_req = 1'b0;
      end
      if ((t_kind == T_NONE || t_kind == T_STORE) && $urandom_range(0, 5) == 0) stray = 1'b1;
    end
  endtask

  task automatic run_cycle();
    @(negedge clk);
    check_cycle();
    obs_grant = {ic_grant, dc_grant};
    obs_mem   = {mem_en, mem_wr, mem_addr, mem_wdata};
    if (ic_grant && !prev_ig) ig_rise = cyc;
    prev_ig = ic_grant;
    if (ic_done) begin idone_cyc = cyc; idone_cnt++; end
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    drive();
  endtask

  task automatic run_until_idle(input string tag, input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      run_cycle();
      if (t_kind == T_NONE && !ic_busy && !dc_busy) return;
    end
    check({tag, "_timeout"}, 64'd1, 64'd0);
  endtask

  task automatic wait_word(input string tag, input bit want_dc, input int k);
    for (int i = 0; i < 50; i++) begin
      if (t_kind == T_FILL && t_dc == want_dc && t_k == k) return;
      run_cycle();
    end
    check({tag, "_timeout"}, 64'd1, 64'd0);
  endtask

  task automatic reset_async(input string tag);
    rst_n = 1'b0;
    #1;
    check(tag, out_vec(), 64'd0);
    t_kind = T_NONE; last_d = 1'b0;
    {started_i, started_d, ended_i, ended_d} = '0;
    {ic_busy, dc_busy, ic_gnt_seen, dc_gnt_seen, prev_ig} = '0;
    ic_req = 1'b0; dc_req = 1'b0; dc_wr = 1'b0; stray = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic req_ic(input logic [15:0] a);
    ic_req = 1'b1; ic_addr = a; ic_busy = 1'b1;
  endtask

  task automatic req_dc(input bit wr, input logic [15:0] a, input logic [15:0] d);
    dc_req = 1'b1; dc_wr = wr; dc_addr = a; dc_wdata = d; dc_busy = 1'b1;
  endtask

  int n0, cnt0;

  initial begin
    ic_req = 1'b0; dc_req = 1'b0; dc_wr = 1'b0;
    ic_addr = '0; dc_addr = '0; dc_wdata = '0;
    reset_async("reset_outputs");

    // Single I fill at 16'h1234: grant at N+1, done at N+8+MEM_LAT.
    req_ic(16'h1234);
    n0 = cyc;
    run_until_idle("ic_fill", 40);
    check("ic_grant_cycle", 64'(ig_rise - n0), 64'd1);
    check("ic_done_cycle", 64'(idone_cyc - n0), 64'(8 + MEM_LAT));

    // Tie after reset goes to D; I follows; a tie after a lone D grant goes to I.
    reset_async("reset_before_tie");
    req_ic(16'h2000);
    req_dc(1'b0, 16'h3008, 16'h0);
    run_cycle();
    run_cycle();
    check("tie1_winner", 64'(obs_grant), 64'(2'b01));
    run_until_idle("tie1", 60);
    req_dc(1'b1, 16'h0102, 16'h5555);
    run_until_idle("lone_store", 10);
    req_ic(16'h4444);
    req_dc(1'b0, 16'h6660, 16'h0);
    run_cycle();
    run_cycle();
    check("tie2_winner", 64'(obs_grant), 64'(2'b10));
    run_until_idle("tie2", 60);

    // Store with odd address: bit 0 forced low.
    req_dc(1'b1, 16'hFFFF, 16'hABCD);
    run_cycle();
    run_cycle();
    check("store_port", 64'(obs_mem), 64'({1'b1, 1'b1, 16'hFFFE, 16'hABCD}));
    run_until_idle("store", 10);

    // Stray return in IDLE must not disturb the next fill's indices.
    stray = 1'b1;
    run_cycle();
    req_ic(16'h7A5E);
    run_until_idle("after_stray", 40);

    // I drops its request at word 3; the fill still completes once.
    cnt0 = idone_cnt;
    req_ic(16'h9abc);
    wait_word("drop", 1'b0, 3);
    ic_req = 1'b0;
    run_until_idle("drop", 40);
    check("drop_done_count", 64'(idone_cnt - cnt0), 64'd1);

    // Reset during word 5 of a D fill, then a clean I fill.
    req_dc(1'b0, 16'hC0DE, 16'h0);
    wait_word("midreset", 1'b1, 5);
    #2;
    reset_async("reset_mid_fill");
    req_ic(16'h0F00);
    run_until_idle("post_reset", 40);

    // Random traffic.
    rand_mode = 1'b1;
    for (int i = 0; i < 3000; i++) run_cycle();
    rand_mode = 1'b0;
    ic_req = ic_busy ? ic_req : 1'b0;
    dc_req = dc_busy ? dc_req : 1'b0;
    run_until_idle("drain", 200);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
